// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared helpers for the RAM-backed FIFO controller.
package ram_fifo_ctrl_pkg;

    // Ceiling log2 that never returns less than 1, so a 1-entry store still gets an address bit.
    function automatic int clog2s(input int value);
        int result;
        result = 1;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/ram_2clk_1w_1r.sv
// Simple dual-port RAM: one write port on CLKA, one registered read port on CLKB.
module ram_2clk_1w_1r
    import ram_fifo_ctrl_pkg::*;
#(
    parameter int C_RAM_WIDTH = 32,
    parameter int C_RAM_DEPTH = 1024,
    localparam int C_RAM_AW   = clog2s(C_RAM_DEPTH)
) (
    input  logic                   CLKA,
    input  logic                   WEA,
    input  logic [C_RAM_AW-1:0]    ADDRA,
    input  logic [C_RAM_WIDTH-1:0] DINA,
    input  logic                   CLKB,
    input  logic                   ENB,
    input  logic [C_RAM_AW-1:0]    ADDRB,
    output logic [C_RAM_WIDTH-1:0] DOUTB
);

    // NOTE: storage has no reset so it maps onto block RAM; contents are undefined until written.
    logic [C_RAM_WIDTH-1:0] mem [C_RAM_DEPTH];

    always_ff @(posedge CLKA) begin
        if (WEA) begin
            mem[ADDRA] <= DINA;
        end
    end

    always_ff @(posedge CLKB) begin
        if (ENB) begin
            DOUTB <= mem[ADDRB];
        end
    end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// Single-clock FIFO controller: pointers, occupancy count and registered status flags around a dual-port RAM.
module ram_fifo_ctrl
    import ram_fifo_ctrl_pkg::*;
#(
    parameter int C_WIDTH        = 32,
    parameter int C_DEPTH        = 1024,
    parameter int C_AFULL_THRESH = C_DEPTH - 4,
    localparam int C_AW          = clog2s(C_DEPTH),
    localparam int C_CW          = clog2s(C_DEPTH) + 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               WR_EN,
    input  logic [C_WIDTH-1:0] WR_DATA,
    input  logic               RD_EN,
    output logic [C_WIDTH-1:0] RD_DATA,
    output logic               RD_VALID,
    output logic               FULL,
    output logic               EMPTY,
    output logic               ALMOST_FULL,
    output logic [C_CW-1:0]    COUNT,
    output logic               OVERFLOW,
    output logic               UNDERFLOW
);

    logic [C_AW-1:0] wr_ptr;
    logic [C_AW-1:0] rd_ptr;
    logic [C_CW-1:0] count;
    logic [C_CW-1:0] count_next;
    logic            wr_accept;
    logic            rd_accept;

    // Qualify against the registered flags only, so a same-cycle read never frees room for a write at FULL.
    assign wr_accept = WR_EN & ~FULL;
    assign rd_accept = RD_EN & ~EMPTY;

    always_comb begin
        count_next = count;
        case ({wr_accept, rd_accept})
            2'b10:   count_next = count + C_CW'(1);
            2'b01:   count_next = count - C_CW'(1);
            default: count_next = count;
        endcase
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            EMPTY       <= 1'b1;
            FULL        <= 1'b0;
            ALMOST_FULL <= 1'b0;
            RD_VALID    <= 1'b0;
            OVERFLOW    <= 1'b0;
            UNDERFLOW   <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + C_AW'(1);
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + C_AW'(1);
            end
            count       <= count_next;
            // Flags are derived from the next count so they line up with COUNT in the same cycle.
            EMPTY       <= (count_next == '0);
            FULL        <= (count_next == C_CW'(C_DEPTH));
            ALMOST_FULL <= (count_next >= C_CW'(C_AFULL_THRESH));
            RD_VALID    <= rd_accept;
            OVERFLOW    <= WR_EN & FULL;
            UNDERFLOW   <= RD_EN & EMPTY;
        end
    end

    assign COUNT = count;

    ram_2clk_1w_1r #(
        .C_RAM_WIDTH (C_WIDTH),
        .C_RAM_DEPTH (C_DEPTH)
    ) u_ram (
        .CLKA  (CLK),
        .WEA   (wr_accept),
        .ADDRA (wr_ptr),
        .DINA  (WR_DATA),
        .CLKB  (CLK),
        .ENB   (rd_accept),
        .ADDRB (rd_ptr),
        .DOUTB (RD_DATA)
    );

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl at C_WIDTH=8, C_DEPTH=4, C_AFULL_THRESH=3.
module tb_ram_fifo_ctrl;

    localparam int W = 8;
    localparam int D = 4;
    localparam int T = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = '0;
    logic       rd_en = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid, full, empty, almost_full, overflow, underflow;
    logic [2:0] count;

    int checks = 0;
    int errors = 0;

    localparam logic [7:0] FILL_DATA [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    localparam logic [2:0] FILL_CNT  [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
    localparam logic       FILL_AF   [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    localparam logic       FILL_FULL [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    localparam logic [2:0] DRAIN_CNT [4] = '{3'd3, 3'd2, 3'd1, 3'd0};
    localparam logic [7:0] B2B_EXP  [12] = '{8'hA0, 8'hA1, 8'h00, 8'h01, 8'h02, 8'h03,
                                             8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};

    always #5 clk = ~clk;

    ram_fifo_ctrl #(
        .C_WIDTH        (W),
        .C_DEPTH        (D),
        .C_AFULL_THRESH (T)
    ) dut (
        .CLK         (clk),
        .RST         (rst),
        .WR_EN       (wr_en),
        .WR_DATA     (wr_data),
        .RD_EN       (rd_en),
        .RD_DATA     (rd_data),
        .RD_VALID    (rd_valid),
        .FULL        (full),
        .EMPTY       (empty),
        .ALMOST_FULL (almost_full),
        .COUNT       (count),
        .OVERFLOW    (overflow),
        .UNDERFLOW   (underflow)
    );

    // Advance past one rising edge and let outputs settle before sampling or driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
        checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_afull: got %b expected 0", almost_full); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
        checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL reset_ovf_unf: got %b%b expected 00", overflow, underflow); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1;
            wr_data = FILL_DATA[i];
            tick();
            checks++; if (count !== FILL_CNT[i]) begin errors++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, count, FILL_CNT[i]); end
            checks++; if (almost_full !== FILL_AF[i]) begin errors++; $display("FAIL fill_afull[%0d]: got %b expected %b", i, almost_full, FILL_AF[i]); end
            checks++; if (full !== FILL_FULL[i]) begin errors++; $display("FAIL fill_full[%0d]: got %b expected %b", i, full, FILL_FULL[i]); end
            checks++; if (empty !== 1'b0) begin errors++; $display("FAIL fill_empty[%0d]: got %b expected 0", i, empty); end
        end
        wr_en = 1'b0;
    endtask

    task automatic test_overflow();
        wr_en = 1'b1;
        wr_data = 8'h55;
        tick();
        wr_en = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_pulse: got %b expected 1", overflow); end
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL ovf_count: got %0d expected 4", count); end
        tick();
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_one_cycle: got %b expected 0", overflow); end
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL ovf_count_hold: got %0d expected 4", count); end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 4; i++) begin
            rd_en = 1'b1;
            tick();
            checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL drain_valid[%0d]: got %b expected 1", i, rd_valid); end
            checks++; if (rd_data !== FILL_DATA[i]) begin errors++; $display("FAIL drain_data[%0d]: got %h expected %h", i, rd_data, FILL_DATA[i]); end
            checks++; if (count !== DRAIN_CNT[i]) begin errors++; $display("FAIL drain_count[%0d]: got %0d expected %0d", i, count, DRAIN_CNT[i]); end
        end
        rd_en = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b expected 1", empty); end
        tick();
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL drain_valid_idle: got %b expected 0", rd_valid); end
    endtask

    task automatic test_underflow();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL unf_pulse: got %b expected 1", underflow); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL unf_rd_valid: got %b expected 0", rd_valid); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL unf_count: got %0d expected 0", count); end
        tick();
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL unf_one_cycle: got %b expected 0", underflow); end
    endtask

    task automatic test_back_to_back();
        wr_en = 1'b1;
        wr_data = 8'hA0;
        tick();
        wr_data = 8'hA1;
        tick();
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL b2b_prefill: got %0d expected 2", count); end
        for (int i = 0; i < 10; i++) begin
            wr_en = 1'b1;
            rd_en = 1'b1;
            wr_data = 8'(i);
            tick();
            checks++; if (count !== 3'd2) begin errors++; $display("FAIL b2b_count[%0d]: got %0d expected 2", i, count); end
            checks++; if (rd_valid !== 1'b1 || rd_data !== B2B_EXP[i]) begin
                errors++; $display("FAIL b2b_data[%0d]: got v=%b d=%h expected v=1 d=%h", i, rd_valid, rd_data, B2B_EXP[i]);
            end
        end
        wr_en = 1'b0;
        for (int i = 10; i < 12; i++) begin
            rd_en = 1'b1;
            tick();
            checks++; if (rd_valid !== 1'b1 || rd_data !== B2B_EXP[i]) begin
                errors++; $display("FAIL b2b_tail[%0d]: got v=%b d=%h expected v=1 d=%h", i, rd_valid, rd_data, B2B_EXP[i]);
            end
        end
        rd_en = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL b2b_empty: got %b expected 1", empty); end
    endtask

    task automatic test_reset_inflight();
        wr_en = 1'b1;
        wr_data = 8'hC1;
        tick();
        wr_data = 8'hC2;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b1;
        tick();
        checks++; if (rd_valid !== 1'b1 || rd_data !== 8'hC1) begin
            errors++; $display("FAIL rst_pre_read: got v=%b d=%h expected v=1 d=c1", rd_valid, rd_data);
        end
        rst = 1'b1;
        wr_en = 1'b1;
        tick();
        rst = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rst_inflight_valid: got %b expected 0", rd_valid); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL rst_inflight_count: got %0d expected 0", count); end
        checks++; if (empty !== 1'b1 || full !== 1'b0) begin
            errors++; $display("FAIL rst_inflight_flags: got empty=%b full=%b expected empty=1 full=0", empty, full);
        end
    endtask

    task automatic test_full_rw();
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1;
            wr_data = 8'h31 + 8'(i);
            tick();
        end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL frw_full: got %b expected 1", full); end
        wr_data = 8'h99;
        rd_en = 1'b1;
        tick();
        wr_en = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL frw_overflow: got %b expected 1", overflow); end
        checks++; if (rd_valid !== 1'b1 || rd_data !== 8'h31) begin
            errors++; $display("FAIL frw_read: got v=%b d=%h expected v=1 d=31", rd_valid, rd_data);
        end
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL frw_count: got %0d expected 3", count); end
        checks++; if (full !== 1'b0 || almost_full !== 1'b1) begin
            errors++; $display("FAIL frw_flags: got full=%b afull=%b expected full=0 afull=1", full, almost_full);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (rd_valid !== 1'b1 || rd_data !== 8'h32 + 8'(i)) begin
                errors++; $display("FAIL frw_drain[%0d]: got v=%b d=%h expected v=1 d=%h", i, rd_valid, rd_data, 8'h32 + 8'(i));
            end
        end
        rd_en = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL frw_empty: got %b expected 1", empty); end
    endtask

    initial begin
        #2;
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_underflow();
        test_back_to_back();
        test_reset_inflight();
        test_full_rw();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
